button_auto_repeat: RTL and testbench

//  Downstream of the synchronizer/debouncer chain; an alternative to the plain edge detector.
//  - Per debounced button level, emits a 1-cycle pulse on press.
//  - If the button stays held, emits repeat pulses (keyboard-style auto-repeat): one after

---
 rtl/button_auto_repeat_pkg.sv | 21 ++
 rtl/button_auto_repeat_channel.sv | 87 ++++++++
 rtl/button_auto_repeat.sv | 41 ++++
 tb/tb_button_auto_repeat.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/button_auto_repeat_pkg.sv
// Shared state encoding, default 33 MHz timing and counter sizing helper
// for the button auto-repeat block.
package button_auto_repeat_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_REPEAT = 2'd2
  } state_t;

  localparam int DEF_INITIAL_DELAY = 16_500_000;  // 0.5 s at 33 MHz
  localparam int DEF_REPEAT_PERIOD = 3_300_000;   // 0.1 s at 33 MHz

  // Counter only has to reach max(delay, period)-1, so clog2 of the larger one suffices.
  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/button_auto_repeat_channel.sv
// One auto-repeat channel: IDLE/DELAY/REPEAT FSM, elapsed-cycle counter and
// registered pulse/repeating outputs.
module button_auto_repeat_channel
  import button_auto_repeat_pkg::*;
#(
  parameter int INITIAL_DELAY = DEF_INITIAL_DELAY,
  parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
  input  logic clk,
  input  logic rst_b,
  input  logic level,
  output logic pulse,
  output logic repeating
);

  localparam int CNT_W = cnt_width(INITIAL_DELAY, REPEAT_PERIOD);
  localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(INITIAL_DELAY - 1);
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_PERIOD - 1);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             pulse_reg, pulse_next;
  logic             rep_reg, rep_next;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      pulse_reg <= 1'b0;
      rep_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      pulse_reg <= pulse_next;
      rep_reg   <= rep_next;
    end
  end

  // A low level always returns to IDLE first, so a release that coincides
  // with a terminal count suppresses that pulse.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    pulse_next = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        cnt_next = '0;
        if (level) begin
          state_next = ST_DELAY;
          pulse_next = 1'b1;
        end
      end
      ST_DELAY: begin
        if (!level) begin
          state_next = ST_IDLE;
          cnt_next   = '0;
        end else if (cnt_reg == DELAY_LAST) begin
          state_next = ST_REPEAT;
          cnt_next   = '0;
          pulse_next = 1'b1;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      ST_REPEAT: begin
        if (!level) begin
          state_next = ST_IDLE;
          cnt_next   = '0;
        end else if (cnt_reg == REPEAT_LAST) begin
          cnt_next   = '0;
          pulse_next = 1'b1;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      default: begin
        state_next = ST_IDLE;
        cnt_next   = '0;
      end
    endcase
    rep_next = (state_next == ST_REPEAT);
  end

  assign pulse     = pulse_reg;
  assign repeating = rep_reg;

endmodule

// File: rtl/button_auto_repeat.sv
// Keyboard-style auto-repeat for `width` debounced buttons: press pulse, then
// repeat pulses while held. Disabling looks like a release on every channel.
module button_auto_repeat
  import button_auto_repeat_pkg::*;
#(
  parameter int width         = 1,
  parameter int INITIAL_DELAY = DEF_INITIAL_DELAY,
  parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             enable,
  input  logic [width-1:0] level_in,
  output logic [width-1:0] pulse_out,
  output logic [width-1:0] repeating
);

  if (INITIAL_DELAY < 2) begin : g_bad_initial_delay
    $error("button_auto_repeat: INITIAL_DELAY must be >= 2");
  end
  if (REPEAT_PERIOD < 2) begin : g_bad_repeat_period
    $error("button_auto_repeat: REPEAT_PERIOD must be >= 2");
  end

  logic [width-1:0] level_gated;
  assign level_gated = level_in & {width{enable}};

  for (genvar gi = 0; gi < width; gi++) begin : g_ch
    button_auto_repeat_channel #(
      .INITIAL_DELAY(INITIAL_DELAY),
      .REPEAT_PERIOD(REPEAT_PERIOD)
    ) u_ch (
      .clk      (clk),
      .rst_b    (rst_b),
      .level    (level_gated[gi]),
      .pulse    (pulse_out[gi]),
      .repeating(repeating[gi])
    );
  end

endmodule

// File: tb/tb_button_auto_repeat.sv
// Randomized and directed bench for button_auto_repeat against an elapsed-time
// reference model of press/repeat pulse timing.
module tb_button_auto_repeat;

  localparam int W  = 3;
  localparam int ID = 10;
  localparam int RP = 4;

  logic         clk = 1'b0;
  logic         rst_b;
  logic         enable;
  logic [W-1:0] level_in;
  logic [W-1:0] pulse_out;
  logic [W-1:0] repeating;

  int vectors    = 0;
  int miscompare = 0;

  // Reference model: per channel, whether a press is in progress and how many
  // edges have elapsed since the press edge.
  bit           active [W];
  int           elapsed[W];
  logic [W-1:0] exp_pulse;
  logic [W-1:0] exp_rep;

  button_auto_repeat #(
    .width        (W),
    .INITIAL_DELAY(ID),
    .REPEAT_PERIOD(RP)
  ) dut (
    .clk      (clk),
    .rst_b    (rst_b),
    .enable   (enable),
    .level_in (level_in),
    .pulse_out(pulse_out),
    .repeating(repeating)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompare++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < W; i++) begin
      active[i]  = 1'b0;
      elapsed[i] = 0;
    end
    exp_pulse = '0;
    exp_rep   = '0;
  endtask

  task automatic model_step(input logic en, input logic [W-1:0] lvl);
    for (int i = 0; i < W; i++) begin
      if (en && lvl[i]) begin
        if (!active[i]) begin
          active[i]    = 1'b1;
          elapsed[i]   = 0;
          exp_pulse[i] = 1'b1;
          exp_rep[i]   = 1'b0;
        end else begin
          elapsed[i]++;
          exp_pulse[i] = (elapsed[i] == ID) ||
                         (elapsed[i] > ID && ((elapsed[i] - ID) % RP) == 0);
          exp_rep[i]   = (elapsed[i] >= ID);
        end
      end else begin
        active[i]    = 1'b0;
        elapsed[i]   = 0;
        exp_pulse[i] = 1'b0;
        exp_rep[i]   = 1'b0;
      end
    end
  endtask

  // Called just after a negedge: drive inputs, advance model, check at next negedge.
  task automatic cycle(input logic en, input logic [W-1:0] lvl);
    enable   = en;
    level_in = lvl;
    model_step(en, lvl);
    @(negedge clk);
    chk("pulse_out", 32'(pulse_out), 32'(exp_pulse));
    chk("repeating", 32'(repeating), 32'(exp_rep));
  endtask

  initial begin
    int npulse;
    logic [W-1:0] lv;
    logic en;

    rst_b    = 1'b0;
    enable   = 1'b0;
    level_in = '0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("reset_pulse", 32'(pulse_out), 32'(0));
    chk("reset_rep", 32'(repeating), 32'(0));
    rst_b = 1'b1;
    repeat (4) cycle(1'b1, 3'b000);

    // Short press on ch0: single pulse, no repeat.
    repeat (3) cycle(1'b1, 3'b001);
    repeat (3) cycle(1'b1, 3'b000);

    // Long hold on ch0: press pulse plus seven repeats over 35 held edges.
    npulse = 0;
    for (int k = 0; k < 35; k++) begin
      cycle(1'b1, 3'b001);
      npulse += int'(pulse_out[0]);
    end
    chk("hold_pulse_count", 32'(npulse), 32'(8));
    chk("hold_repeating", 32'(repeating[0]), 32'(1));
    repeat (2) cycle(1'b1, 3'b000);
    chk("after_release_rep", 32'(repeating), 32'(0));

    // Release ch1 exactly on the edge that would give the first repeat.
    repeat (ID) cycle(1'b1, 3'b010);
    cycle(1'b1, 3'b000);
    chk("release_on_terminal", 32'(pulse_out[1]), 32'(0));
    repeat (2) cycle(1'b1, 3'b000);

    // Simultaneous ch0/ch2 press, one-cycle enable drop in DELAY, re-press.
    cycle(1'b1, 3'b101);
    chk("simul_press", 32'(pulse_out), 32'(3'b101));
    repeat (3) cycle(1'b1, 3'b101);
    cycle(1'b0, 3'b101);
    cycle(1'b1, 3'b101);
    chk("reenable_press", 32'(pulse_out), 32'(3'b101));
    repeat (4) cycle(1'b1, 3'b101);
    repeat (2) cycle(1'b1, 3'b000);

    // Asynchronous reset mid-REPEAT with the button still held.
    repeat (ID + 6) cycle(1'b1, 3'b100);
    #2 rst_b = 1'b0;
    #1;
    chk("async_rst_pulse", 32'(pulse_out), 32'(0));
    chk("async_rst_rep", 32'(repeating), 32'(0));
    model_reset();
    @(negedge clk);
    rst_b = 1'b1;
    cycle(1'b1, 3'b100);
    chk("held_through_reset", 32'(pulse_out[2]), 32'(1));
    repeat (ID + 2) cycle(1'b1, 3'b100);
    repeat (2) cycle(1'b1, 3'b000);

    // Press, one-cycle release, re-press: two press pulses two cycles apart.
    cycle(1'b1, 3'b010);
    cycle(1'b1, 3'b000);
    cycle(1'b1, 3'b010);
    chk("repress_pulse", 32'(pulse_out[1]), 32'(1));
    repeat (ID + 3) cycle(1'b1, 3'b010);
    repeat (2) cycle(1'b1, 3'b000);

    // Random levels with long holds and occasional enable drops.
    lv = '0;
    for (int k = 0; k < 3000; k++) begin
      for (int i = 0; i < W; i++)
        if ($urandom_range(0, 11) == 0) lv[i] = ~lv[i];
      en = ($urandom_range(0, 59) != 0);
      cycle(en, lv);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompare);
    $finish;
  end

endmodule
